fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipelined CPU. Owns the PC register, issues one

---
 rtl/wisc_pkg.sv | 19 +
 rtl/fetch_unit_cla.sv | 46 ++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC pipeline: opcodes, NOP encoding, fetch FSM states.
package wisc_pkg;

   localparam logic [3:0]  HLT_OPCODE = 4'hF;
   localparam logic [15:0] NOP_ENC    = 16'h0000;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_WAIT  = 3'd1,
      S_HOLD  = 3'd2,
      S_DROP  = 3'd3,
      S_HALT  = 3'd4
   } fetch_state_t;

   function automatic logic is_hlt(input logic [15:0] instr);
      return instr[15:12] == HLT_OPCODE;
   endfunction

endpackage

// File: rtl/fetch_unit_cla.sv
// 16-bit carry-lookahead adder/subtractor: four 4-bit lookahead groups with lookahead group carries.
module CLA_16b (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_sub,
   output logic [15:0] o_sum
);

   logic [15:0] w_b;
   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [15:0] w_c;
   logic [3:0]  w_gc;

   function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   function automatic logic [3:0] grp_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic cin);
      logic [3:0] c;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

   always_comb begin
      w_b     = i_b ^ {16{i_sub}};
      w_g     = i_a & w_b;
      w_p     = i_a ^ w_b;
      w_gc    = '0;
      w_gc[0] = i_sub;
      for (int unsigned grp = 0; grp < 3; grp++) begin
         w_gc[grp+1] = grp_gen(w_g[grp*4 +: 4], w_p[grp*4 +: 4])
                     | (&w_p[grp*4 +: 4] & w_gc[grp]);
      end
      for (int unsigned grp = 0; grp < 4; grp++) begin
         w_c[grp*4 +: 4] = grp_carries(w_g[grp*4 +: 4], w_p[grp*4 +: 4], w_gc[grp]);
      end
   end

   assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM, stall skid and IF/ID register.
module fetch_unit
   import wisc_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2,
   output logic        halted
);

   fetch_state_t r_state;
   fetch_state_t w_state_nx;
   logic [15:0]  r_pc;
   logic [15:0]  w_pc_nx;
   logic [15:0]  w_pc_plus2;
   logic [15:0]  r_skid;
   logic         w_skid_load;
   logic         w_ifid_load;
   logic [15:0]  w_ifid_instr;
   logic         r_if_valid;
   logic [15:0]  r_if_instr;
   logic [15:0]  r_if_pc;
   logic [15:0]  r_if_pc_plus2;

   CLA_16b u_pc_add (
      .i_a   (r_pc),
      .i_b   (16'h0002),
      .i_sub (1'b0),
      .o_sum (w_pc_plus2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_skid        <= NOP_INSTR;
         r_if_valid    <= 1'b0;
         r_if_instr    <= NOP_INSTR;
         r_if_pc       <= '0;
         r_if_pc_plus2 <= '0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         if (w_skid_load) r_skid <= imem_data;
         if (redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
         end else if (w_ifid_load) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= w_ifid_instr;
            r_if_pc       <= r_pc;
            r_if_pc_plus2 <= w_pc_plus2;
         end else if (!stall) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
         end
      end
   end

   // pc only advances when the fetched word is consumed; a HLT leaves pc pointing at itself.
   always_comb begin
      w_state_nx   = r_state;
      w_pc_nx      = r_pc;
      w_skid_load  = 1'b0;
      w_ifid_load  = 1'b0;
      w_ifid_instr = imem_data;
      unique case (r_state)
         S_FETCH: begin
            if (redirect_valid) w_pc_nx = redirect_pc;
            else                w_state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid) begin
               w_pc_nx    = redirect_pc;
               w_state_nx = imem_rdy ? S_FETCH : S_DROP;
            end else if (imem_rdy && stall) begin
               w_skid_load = 1'b1;
               w_state_nx  = S_HOLD;
            end else if (imem_rdy) begin
               w_ifid_load = 1'b1;
               if (is_hlt(imem_data)) begin
                  w_state_nx = S_HALT;
               end else begin
                  w_pc_nx    = w_pc_plus2;
                  w_state_nx = S_FETCH;
               end
            end
         end
         S_HOLD: begin
            w_ifid_instr = r_skid;
            if (redirect_valid) begin
               w_pc_nx    = redirect_pc;
               w_state_nx = S_FETCH;
            end else if (!stall) begin
               w_ifid_load = 1'b1;
               if (is_hlt(r_skid)) begin
                  w_state_nx = S_HALT;
               end else begin
                  w_pc_nx    = w_pc_plus2;
                  w_state_nx = S_FETCH;
               end
            end
         end
         S_DROP: begin
            if (redirect_valid) w_pc_nx = redirect_pc;
            if (imem_rdy)       w_state_nx = S_FETCH;
         end
         S_HALT: begin
            if (redirect_valid) begin
               w_pc_nx    = redirect_pc;
               w_state_nx = S_FETCH;
            end
         end
         default: w_state_nx = S_FETCH;
      endcase
   end

   // A redirect in FETCH retargets pc instead of issuing, so no stale response is ever owed.
   assign imem_req    = (r_state == S_FETCH) && !rst && !redirect_valid;
   assign imem_addr   = r_pc;
   assign halted      = (r_state == S_HALT);
   assign if_valid    = r_if_valid;
   assign if_instr    = r_if_instr;
   assign if_pc       = r_if_pc;
   assign if_pc_plus2 = r_if_pc_plus2;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction-memory responder.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_lat = 1;

   fetch_unit #(
      .RESET_PC  (16'h0000),
      .NOP_INSTR (16'h0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdy       (imem_rdy),
      .imem_data      (imem_data),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus2    (if_pc_plus2),
      .halted         (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] mem_word(input logic [15:0] addr);
      case (addr)
         16'h0000: return 16'h1111;
         16'h0002: return 16'h2222;
         16'h0004: return 16'h3333;
         16'h0008: return 16'hF000;
         default:  return 16'h5000 | {4'h0, addr[11:0]};
      endcase
   endfunction

   // Memory responder: acts on negedges, answers each request mem_lat cycles later.
   initial begin
      logic        pend;
      int          cnt;
      logic [15:0] pend_addr;
      pend      = 1'b0;
      cnt       = 0;
      pend_addr = '0;
      imem_rdy  = 1'b0;
      imem_data = '0;
      forever begin
         @(negedge clk);
         imem_rdy = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rdy  = 1'b1;
               imem_data = mem_word(pend_addr);
               pend      = 1'b0;
            end
         end
         if (imem_req === 1'b1) begin
            pend      = 1'b1;
            cnt       = mem_lat;
            pend_addr = imem_addr;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(); tick(); tick();
      n_tests++;
      if ({imem_req, if_valid, halted} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: req/valid/halted got %b want 000", {imem_req, if_valid, halted});
      end
      n_tests++;
      if ({if_instr, if_pc, if_pc_plus2} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_ifid: got %h want 000000000000", {if_instr, if_pc, if_pc_plus2});
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL first_req: req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_basic();
      tick();
      n_tests++;
      if ({if_valid, imem_req} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_wait: valid/req got %b want 00", {if_valid, imem_req});
      end
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2} !== {1'b1, 16'h1111, 16'h0000, 16'h0002}) begin
         n_fail++;
         $display("FAIL basic_instr0: got v=%b %h pc=%h p2=%h want v=1 1111 pc=0000 p2=0002",
                  if_valid, if_instr, if_pc, if_pc_plus2);
      end
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin
         n_fail++;
         $display("FAIL basic_req1: req=%b addr=%h want req=1 addr=0002", imem_req, imem_addr);
      end
      tick();
      n_tests++;
      if ({if_valid, if_instr} !== {1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL basic_bubble: got v=%b %h want v=0 0000", if_valid, if_instr);
      end
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2} !== {1'b1, 16'h2222, 16'h0002, 16'h0004}) begin
         n_fail++;
         $display("FAIL basic_instr1: got v=%b %h pc=%h p2=%h want v=1 2222 pc=0002 p2=0004",
                  if_valid, if_instr, if_pc, if_pc_plus2);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc} !== {1'b1, 16'h2222, 16'h0002}) begin
         n_fail++;
         $display("FAIL stall_hold0: got v=%b %h pc=%h want v=1 2222 pc=0002", if_valid, if_instr, if_pc);
      end
      tick();
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, imem_req} !== {1'b1, 16'h2222, 16'h0002, 1'b0}) begin
         n_fail++;
         $display("FAIL stall_hold1: got v=%b %h pc=%h req=%b want v=1 2222 pc=0002 req=0",
                  if_valid, if_instr, if_pc, imem_req);
      end
      stall = 1'b0;
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2} !== {1'b1, 16'h3333, 16'h0004, 16'h0006}) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b %h pc=%h p2=%h want v=1 3333 pc=0004 p2=0006",
                  if_valid, if_instr, if_pc, if_pc_plus2);
      end
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin
         n_fail++;
         $display("FAIL stall_norefetch: req=%b addr=%h want req=1 addr=0006", imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      mem_lat = 3;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_tests++;
      if ({if_valid, if_instr, imem_req} !== {1'b0, 16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL redir_flush: got v=%b %h req=%b want v=0 0000 req=0", if_valid, if_instr, imem_req);
      end
      tick();
      tick();
      n_tests++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0100, 1'b0}) begin
         n_fail++;
         $display("FAIL redir_refetch: req=%b addr=%h v=%b want req=1 addr=0100 v=0",
                  imem_req, imem_addr, if_valid);
      end
      mem_lat = 1;
      tick();
      n_tests++;
      if (if_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_stale: v=%b instr=%h want v=0", if_valid, if_instr);
      end
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2} !== {1'b1, 16'h5100, 16'h0100, 16'h0102}) begin
         n_fail++;
         $display("FAIL redir_target: got v=%b %h pc=%h p2=%h want v=1 5100 pc=0100 p2=0102",
                  if_valid, if_instr, if_pc, if_pc_plus2);
      end
   endtask

   task automatic test_redirect_stall();
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0200;
      tick();
      n_tests++;
      if ({if_valid, if_instr} !== {1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL redir_stall_flush: got v=%b %h want v=0 0000", if_valid, if_instr);
      end
      stall          = 1'b0;
      redirect_valid = 1'b0;
      #1;
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0200}) begin
         n_fail++;
         $display("FAIL redir_stall_req: req=%b addr=%h want req=1 addr=0200", imem_req, imem_addr);
      end
      tick();
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc} !== {1'b1, 16'h5200, 16'h0200}) begin
         n_fail++;
         $display("FAIL redir_stall_instr: got v=%b %h pc=%h want v=1 5200 pc=0200", if_valid, if_instr, if_pc);
      end
   endtask

   task automatic test_halt();
      int req_seen;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0008;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2} !== {1'b1, 16'hF000, 16'h0008, 16'h000A}) begin
         n_fail++;
         $display("FAIL halt_instr: got v=%b %h pc=%h p2=%h want v=1 f000 pc=0008 p2=000a",
                  if_valid, if_instr, if_pc, if_pc_plus2);
      end
      n_tests++;
      if ({halted, imem_req} !== 2'b10) begin
         n_fail++;
         $display("FAIL halt_flag: halted/req got %b want 10", {halted, imem_req});
      end
      req_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (imem_req !== 1'b0 || halted !== 1'b1) req_seen++;
      end
      n_tests++;
      if (req_seen != 0) begin
         n_fail++;
         $display("FAIL halt_quiet: %0d cycles with req or !halted, want 0", req_seen);
      end
      n_tests++;
      if (if_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_bubble: v=%b want 0", if_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_tests++;
      if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
         n_fail++;
         $display("FAIL halt_exit: halted=%b req=%b addr=%h want halted=0 req=1 addr=0040",
                  halted, imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      rst = 1'b1;
      tick(); tick(); tick();
      rst            = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2} !== {1'b1, 16'h5FFE, 16'hFFFE, 16'h0000}) begin
         n_fail++;
         $display("FAIL wrap_ifid: got v=%b %h pc=%h p2=%h want v=1 5ffe pc=fffe p2=0000",
                  if_valid, if_instr, if_pc, if_pc_plus2);
      end
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL wrap_addr: req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_in_wait();
      mem_lat = 2;
      tick();
      rst = 1'b1;
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc, if_pc_plus2, halted, imem_req} !== 51'h0) begin
         n_fail++;
         $display("FAIL rst_wait_outputs: v=%b %h pc=%h p2=%h h=%b req=%b want all zero",
                  if_valid, if_instr, if_pc, if_pc_plus2, halted, imem_req);
      end
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL rst_wait_ignored: v=%b req=%b addr=%h want v=0 req=1 addr=0000",
                  if_valid, imem_req, imem_addr);
      end
      tick();
      tick();
      n_tests++;
      if (if_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait_latency: v=%b want 0", if_valid);
      end
      tick();
      n_tests++;
      if ({if_valid, if_instr, if_pc} !== {1'b1, 16'h1111, 16'h0000}) begin
         n_fail++;
         $display("FAIL rst_wait_refetch: got v=%b %h pc=%h want v=1 1111 pc=0000", if_valid, if_instr, if_pc);
      end
      mem_lat = 1;
   endtask

   initial begin
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_redirect_stall();
      test_halt();
      test_wrap();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
